// File: rtl/mips_mem_bridge.sv
// mips_mem_bridge
// ---------------
// Puts the CPU's separate instruction and data ports onto one shared memory
// bus that may insert wait states. Each CPU step becomes a fetch phase and/or
// a data phase, done one after the other. The core is frozen through
// cpu_stall until the single RESP cycle. A transfer that waits too long is
// aborted and raises the sticky bus_error flag.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   instr_req/address     fetch request and address from the core
//   instr_readdata/valid  latched fetch data, valid in the RESP cycle
//   data_read/write       load / store request (both set = store)
//   data_address          load/store address
//   data_byteenable       lane mask
//   data_writedata        store data
//   data_readdata/valid   latched load data, load/store done in RESP
//   cpu_stall             core must hold its state and requests
//   bus_*                 shared memory bus master port (word-aligned)
//   bus_error             sticky timeout flag, cleared only by reset
module mips_mem_bridge #(
   parameter  int ADDR_W     = 32,
   parameter  int DATA_W     = 32,
   parameter  int MAX_WAIT   = 16,
   parameter  int DATA_FIRST = 0,
   localparam int BE_W       = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_req,
   input  logic [ADDR_W-1:0] instr_address,
   output logic [DATA_W-1:0] instr_readdata,
   output logic              instr_valid,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [ADDR_W-1:0] data_address,
   input  logic [BE_W-1:0]   data_byteenable,
   input  logic [DATA_W-1:0] data_writedata,
   output logic [DATA_W-1:0] data_readdata,
   output logic              data_valid,
   output logic              cpu_stall,
   output logic [ADDR_W-1:0] bus_address,
   output logic              bus_read,
   output logic              bus_write,
   output logic [BE_W-1:0]   bus_byteenable,
   output logic [DATA_W-1:0] bus_writedata,
   input  logic [DATA_W-1:0] bus_readdata,
   input  logic              bus_waitrequest,
   output logic              bus_error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Wide enough to hold MAX_WAIT itself.
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic [DATA_W-1:0]  instr_rdata_reg;
   logic [DATA_W-1:0]  data_rdata_reg;
   logic               fetch_done_reg;
   logic               data_done_reg;
   logic               bus_error_reg;

   logic               data_req;
   logic               any_req;
   logic               in_phase;
   logic               timeout;
   logic               strobe_on;
   logic               xfer_done;

   // The bus is word addressed. The low address bits from the core are
   // ignored on purpose.
   logic [3:0]         unused_addr_bits;
   assign unused_addr_bits = {instr_address[1:0], data_address[1:0]};

   assign data_req  = data_read | data_write;
   assign any_req   = instr_req | data_req;
   assign in_phase  = (state_reg == S_FETCH) || (state_reg == S_DATA);

   // Once the counter reaches the limit, the strobe is already dropped for
   // this cycle. The phase then ends no matter what waitrequest says.
   assign timeout   = (MAX_WAIT > 0) && in_phase &&
                      (wait_cnt_reg == CNT_W'(MAX_WAIT));
   assign strobe_on = in_phase && !timeout;
   assign xfer_done = in_phase && (timeout || !bus_waitrequest);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (any_req) begin
               if (DATA_FIRST != 0) state_next = data_req  ? S_DATA  : S_FETCH;
               else                 state_next = instr_req ? S_FETCH : S_DATA;
            end
         end
         S_FETCH: begin
            if (xfer_done)
               state_next = (DATA_FIRST == 0 && data_req) ? S_DATA : S_RESP;
         end
         S_DATA: begin
            if (xfer_done)
               state_next = (DATA_FIRST != 0 && instr_req) ? S_FETCH : S_RESP;
         end
         default: state_next = S_IDLE;
      endcase

      // Every phase entry starts a fresh wait budget.
      if (state_next != state_reg)
         wait_cnt_next = '0;
      else if (MAX_WAIT > 0 && strobe_on && bus_waitrequest)
         wait_cnt_next = wait_cnt_reg + 1'b1;
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      cpu_stall      = any_req && (state_reg != S_RESP);
      bus_address    = '0;
      bus_read       = 1'b0;
      bus_write      = 1'b0;
      bus_byteenable = '0;
      bus_writedata  = '0;
      instr_valid    = 1'b0;
      data_valid     = 1'b0;
      case (state_reg)
         S_FETCH: begin
            bus_address    = {instr_address[ADDR_W-1:2], 2'b00};
            bus_byteenable = '1;
            bus_read       = strobe_on;
         end
         S_DATA: begin
            bus_address    = {data_address[ADDR_W-1:2], 2'b00};
            bus_byteenable = data_byteenable;
            if (data_write) begin
               bus_write     = strobe_on;
               bus_writedata = data_writedata;
            end else begin
               bus_read      = strobe_on;
            end
         end
         S_RESP: begin
            instr_valid = fetch_done_reg;
            data_valid  = data_done_reg;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_reg    <= '0;
         instr_rdata_reg <= '0;
         data_rdata_reg  <= '0;
         fetch_done_reg  <= 1'b0;
         data_done_reg   <= 1'b0;
         bus_error_reg   <= 1'b0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (timeout)
            bus_error_reg <= 1'b1;
         if (state_reg == S_IDLE) begin
            fetch_done_reg <= 1'b0;
            data_done_reg  <= 1'b0;
         end
         if (state_reg == S_FETCH && xfer_done) begin
            fetch_done_reg  <= 1'b1;
            instr_rdata_reg <= timeout ? '0 : bus_readdata;
         end
         if (state_reg == S_DATA && xfer_done) begin
            data_done_reg <= 1'b1;
            if (!data_write)
               data_rdata_reg <= timeout ? '0 : bus_readdata;
         end
      end
   end

   assign instr_readdata = instr_rdata_reg;
   assign data_readdata  = data_rdata_reg;
   assign bus_error      = bus_error_reg;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Bench for mips_mem_bridge. It runs two instances side by side:
//   u0: DATA_FIRST=0, MAX_WAIT=4
//   u1: DATA_FIRST=1, MAX_WAIT=0 (no timeout)
// For each CPU step, the bench builds a cycle plan from the phase rules.
// The plan lists the expected strobes, addresses and lanes, the waitrequest
// to drive, and the RESP cycle. The bench then runs the plan and checks the
// DUT against it cycle by cycle.
module tb_mips_mem_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        instr_req       [2];
   logic [31:0] instr_address   [2];
   logic [31:0] instr_readdata  [2];
   logic        instr_valid     [2];
   logic        data_read       [2];
   logic        data_write      [2];
   logic [31:0] data_address    [2];
   logic [3:0]  data_byteenable [2];
   logic [31:0] data_writedata  [2];
   logic [31:0] data_readdata   [2];
   logic        data_valid      [2];
   logic        cpu_stall       [2];
   logic [31:0] bus_address     [2];
   logic        bus_read        [2];
   logic        bus_write       [2];
   logic [3:0]  bus_byteenable  [2];
   logic [31:0] bus_writedata   [2];
   logic [31:0] bus_readdata    [2];
   logic        bus_waitrequest [2];
   logic        bus_error       [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mips_mem_bridge #(
         .ADDR_W    (32),
         .DATA_W    (32),
         .MAX_WAIT  ((gi == 0) ? 4 : 0),
         .DATA_FIRST(gi)
      ) u_dut (
         .clk            (clk),
         .reset          (reset),
         .instr_req      (instr_req[gi]),
         .instr_address  (instr_address[gi]),
         .instr_readdata (instr_readdata[gi]),
         .instr_valid    (instr_valid[gi]),
         .data_read      (data_read[gi]),
         .data_write     (data_write[gi]),
         .data_address   (data_address[gi]),
         .data_byteenable(data_byteenable[gi]),
         .data_writedata (data_writedata[gi]),
         .data_readdata  (data_readdata[gi]),
         .data_valid     (data_valid[gi]),
         .cpu_stall      (cpu_stall[gi]),
         .bus_address    (bus_address[gi]),
         .bus_read       (bus_read[gi]),
         .bus_write      (bus_write[gi]),
         .bus_byteenable (bus_byteenable[gi]),
         .bus_writedata  (bus_writedata[gi]),
         .bus_readdata   (bus_readdata[gi]),
         .bus_waitrequest(bus_waitrequest[gi]),
         .bus_error      (bus_error[gi])
      );
   end

   typedef struct {
      bit          rd;
      bit          wr;
      bit          wreq;
      bit          resp;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rdata;
   } cyc_t;

   // Architectural state the CPU should see, per unit.
   logic [31:0] m_irdata [2];
   logic [31:0] m_drdata [2];
   bit          m_err    [2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int u,
                        input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[u%0d]: observed %h expected %h", tag, u, obs, exp);
      end
   endtask

   function automatic cyc_t blank();
      cyc_t c;
      c.rd = 0; c.wr = 0; c.wreq = 0; c.resp = 0;
      c.addr = '0; c.be = '0; c.wd = '0; c.rdata = '0;
      return c;
   endfunction

   task automatic clear_cpu(input int u);
      instr_req[u] = 0; instr_address[u] = '0;
      data_read[u] = 0; data_write[u] = 0; data_address[u] = '0;
      data_byteenable[u] = '0; data_writedata[u] = '0;
      bus_waitrequest[u] = 0; bus_readdata[u] = '0;
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_irdata[u] = '0; m_drdata[u] = '0; m_err[u] = 0;
      end
   endtask

   // One CPU step. Call it at posedge+1 with the unit idle. It returns at
   // posedge+1 after one idle cycle has been checked.
   task automatic do_txn(input int u,
                         input bit ireq, input logic [31:0] iaddr,
                         input logic [31:0] irdata, input int iwait,
                         input bit rd, input bit wr, input logic [31:0] daddr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] drdata, input int dwait);
      cyc_t plan[$];
      cyc_t c;
      int   mw, w, n, resp_idx;
      bit   df, dreq, is_fetch, is_read, tmo, son;
      mw   = (u == 0) ? 4 : 0;
      df   = (u == 1);
      dreq = rd | wr;

      plan.push_back(blank());                    // request seen in IDLE
      for (int p = 0; p < 2; p++) begin
         is_fetch = df ? (p == 1) : (p == 0);
         if (is_fetch ? !ireq : !dreq) continue;
         is_read = is_fetch || !wr;
         w   = is_fetch ? iwait : dwait;
         tmo = (mw > 0) && (w >= mw);
         n   = tmo ? mw : w;
         for (int j = 0; j <= n; j++) begin
            son    = !(tmo && j == n);
            c      = blank();
            c.rd   = son && is_read;
            c.wr   = son && !is_read;
            c.wreq = (j < n) || tmo;
            c.addr = is_fetch ? {iaddr[31:2], 2'b00} : {daddr[31:2], 2'b00};
            c.be   = is_fetch ? 4'hF : be;
            c.wd   = wd;
            c.rdata = is_fetch ? irdata : drdata;
            plan.push_back(c);
         end
         if (tmo) m_err[u] = 1;
         if (is_fetch)     m_irdata[u] = tmo ? 32'h0 : irdata;
         else if (is_read) m_drdata[u] = tmo ? 32'h0 : drdata;
      end
      c = blank();
      c.resp = 1;
      plan.push_back(c);
      resp_idx = plan.size() - 1;

      instr_req[u] = ireq; instr_address[u] = iaddr;
      data_read[u] = rd; data_write[u] = wr; data_address[u] = daddr;
      data_byteenable[u] = be; data_writedata[u] = wd;

      foreach (plan[k]) begin
         bus_waitrequest[u] = plan[k].wreq;
         bus_readdata[u]    = plan[k].wreq ? $urandom : plan[k].rdata;
         @(negedge clk);
         check("cpu_stall",   u, cpu_stall[u],   !plan[k].resp);
         check("bus_read",    u, bus_read[u],    plan[k].rd);
         check("bus_write",   u, bus_write[u],   plan[k].wr);
         check("instr_valid", u, instr_valid[u], plan[k].resp & ireq);
         check("data_valid",  u, data_valid[u],  plan[k].resp & dreq);
         if (plan[k].rd || plan[k].wr) begin
            check("bus_address",    u, bus_address[u],    plan[k].addr);
            check("bus_byteenable", u, bus_byteenable[u], plan[k].be);
         end
         if (plan[k].wr)
            check("bus_writedata", u, bus_writedata[u], plan[k].wd);
         if (plan[k].resp) begin
            check("instr_readdata", u, instr_readdata[u], m_irdata[u]);
            check("data_readdata",  u, data_readdata[u],  m_drdata[u]);
            check("bus_error",      u, bus_error[u],      m_err[u]);
         end
         @(posedge clk); #1;
      end

      clear_cpu(u);
      @(negedge clk);
      check("idle_stall", u, cpu_stall[u], 1'b0);
      check("idle_read",  u, bus_read[u],  1'b0);
      check("idle_write", u, bus_write[u], 1'b0);
      @(posedge clk); #1;
      $display("[TB] txn u%0d i=%0d@%h r=%0d w=%0d d@%h be=%h waits=%0d/%0d resp@%0d err=%0d",
               u, ireq, iaddr, rd, wr, daddr, be, iwait, dwait, resp_idx, m_err[u]);
   endtask

   initial begin
      bit          ri, rr, rw;
      logic [31:0] ra, rb;
      reset = 1'b0;
      for (int u = 0; u < 2; u++) clear_cpu(u);
      model_reset();
      #12;
      for (int u = 0; u < 2; u++) begin
         check("rst_read",   u, bus_read[u],       1'b0);
         check("rst_write",  u, bus_write[u],      1'b0);
         check("rst_addr",   u, bus_address[u],    32'h0);
         check("rst_be",     u, bus_byteenable[u], 4'h0);
         check("rst_wd",     u, bus_writedata[u],  32'h0);
         check("rst_irdata", u, instr_readdata[u], 32'h0);
         check("rst_drdata", u, data_readdata[u],  32'h0);
         check("rst_ival",   u, instr_valid[u],    1'b0);
         check("rst_dval",   u, data_valid[u],     1'b0);
         check("rst_err",    u, bus_error[u],      1'b0);
         check("rst_stall",  u, cpu_stall[u],      1'b0);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // Fetch only, unaligned address
      do_txn(0, 1, 32'h0000_0006, 32'h2402_0005, 0, 0, 0, 0, 0, 0, 0, 0);
      // Fetch plus store, two wait cycles on the store
      do_txn(0, 1, 32'h0000_0040, 32'h1234_5678, 0,
             0, 1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, 0, 2);
      // Data first: the load goes before the fetch
      do_txn(1, 1, 32'h0000_0200, 32'hAAAA_0001, 0,
             1, 0, 32'h0000_0303, 4'hF, 0, 32'hBBBB_0002, 0);
      // No timeout on u1 even after a long wait
      do_txn(1, 1, 32'h0000_0010, 32'hCAFE_F00D, 20, 0, 0, 0, 0, 0, 0, 0);
      // Fetch times out; the load still happens and the error flag stays set
      do_txn(0, 1, 32'h0000_0080, 32'h5555_5555, 30,
             1, 0, 32'h0000_0104, 4'hF, 0, 32'h7777_8888, 1);
      // Load and store together are handled as a store; fetch data holds
      do_txn(0, 0, 0, 0, 0, 1, 1, 32'h0000_0108, 4'b1100, 32'h0BAD_F00D, 0, 0);

      // Reset in the middle of a stalled fetch
      instr_req[0] = 1; instr_address[0] = 32'h0000_0400; bus_waitrequest[0] = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_pre_read", 0, bus_read[0], 1'b1);
      #1 reset = 1'b0;
      #1;
      check("midrst_read",   0, bus_read[0],       1'b0);
      check("midrst_addr",   0, bus_address[0],    32'h0);
      check("midrst_err",    0, bus_error[0],      1'b0);
      check("midrst_irdata", 0, instr_readdata[0], 32'h0);
      clear_cpu(0);
      model_reset();
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("postrst_stall", 0, cpu_stall[0], 1'b0);
      check("postrst_read",  0, bus_read[0],  1'b0);
      check("postrst_err",   0, bus_error[0], 1'b0);
      do_txn(0, 1, 32'h0000_0400, 32'h0101_0101, 1, 0, 0, 0, 0, 0, 0, 0);

      // Random steps
      for (int t = 0; t < 40; t++) begin
         ri = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         if (!ri && !rr && !rw) ri = 1;
         ra = $urandom;
         rb = $urandom;
         do_txn(t % 2, ri, ra, $urandom, $urandom_range(0, 5),
                rr, rw, rb, 4'($urandom_range(1, 15)), $urandom, $urandom,
                $urandom_range(0, 5));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mem_bridge.md
Name: mips_mem_bridge

Overview:
- Bridges the CPU's Harvard-style instruction and data ports onto a single shared memory bus with wait states.
- Serialises each CPU step into an instruction fetch phase and an optional data phase.
- Stalls the core through `cpu_stall`, which drives the core's `clk_enable` as its inverse.
- Adds byte enables, phase ordering and a bus timeout with a sticky error flag, which the direct Harvard connection lacks.

Parameters:
- ADDR_W, 32, address width of CPU and bus ports.
- DATA_W, 32, data width; must be a multiple of 8. BE_W = DATA_W/8 (localparam).
- MAX_WAIT, 16, waitrequest cycles tolerated per transfer before abort; 0 disables the timeout.
- DATA_FIRST, 0, if 1 the data phase precedes the fetch phase.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_req  in  1  CPU requests a fetch this step.
- instr_address  in  ADDR_W  fetch address.
- instr_readdata  out  DATA_W  latched fetch data.
- instr_valid  out  1  fetch data valid (RESP cycle only).
- data_read  in  1  CPU load request.
- data_write  in  1  CPU store request.
- data_address  in  ADDR_W  load/store address.
- data_byteenable  in  BE_W  store/load lane mask.
- data_writedata  in  DATA_W  store data.
- data_readdata  out  DATA_W  latched load data.
- data_valid  out  1  load/store complete (RESP cycle only).
- cpu_stall  out  1  core must hold its state and requests.
- bus_address  out  ADDR_W  word-aligned bus address.
- bus_read  out  1  bus read strobe.
- bus_write  out  1  bus write strobe.
- bus_byteenable  out  BE_W  bus lane mask.
- bus_writedata  out  DATA_W  bus write data.
- bus_readdata  in  DATA_W  bus read data.
- bus_waitrequest  in  1  slave not ready.
- bus_error  out  1  sticky timeout flag.

Behaviour:

States are IDLE, FETCH, DATA and RESP.

Reset:
- Asserting reset (low) forces the following immediately, including mid-transfer: state IDLE, all bus strobes 0, bus_address/byteenable/writedata 0, instr_readdata/data_readdata 0, valids 0, bus_error 0, timeout counter 0.
- No partial transfer resumes after reset.

Stall:
- cpu_stall = (instr_req | data_read | data_write) & (state != RESP). It is combinational.
- The CPU holds all request inputs stable while cpu_stall = 1.

IDLE:
- Any request moves to the first required phase.
- Phase order is FETCH then DATA, or DATA then FETCH when DATA_FIRST = 1.
- Phases that are not requested are skipped.

FETCH:
- Outputs: bus_read = 1, bus_byteenable all ones, bus_address = {instr_address[ADDR_W-1:2], 2'b00}.

DATA:
- Outputs: bus_address aligned the same way, bus_byteenable = data_byteenable.
- data_write = 1 drives bus_write and bus_writedata = data_writedata; otherwise bus_read.
- data_read & data_write together is treated as a write.

Transfer completion:
- A transfer completes in the cycle where its strobe is 1 and bus_waitrequest = 0.
- Read data is captured from bus_readdata in that cycle.
- The FSM then advances to the next phase, or to RESP.
- Strobes deassert in the cycle after completion.
- There is no back-to-back strobe across phases without an intervening registered transition.

RESP:
- Lasts exactly one cycle: cpu_stall = 0, instr_valid/data_valid = 1 for the phases performed.
- Next state is IDLE.
- Latched readdata holds until the next capture.

Latency with zero wait states:
- Fetch only: request seen in IDLE at cycle 0, FETCH at cycle 1, RESP at cycle 2.
- Fetch plus data: RESP at cycle 3.
- Each wait cycle adds 1.

Timeout:
- A counter increments each cycle the strobe is held with waitrequest = 1, and clears on phase entry.
- When the counter reaches MAX_WAIT (MAX_WAIT > 0): drop the strobe, capture 0 as read data, set bus_error, and proceed as if the phase completed.
- bus_error clears only on reset.

No request:
- With no request in IDLE, the FSM stays in IDLE, cpu_stall = 0 and the bus stays idle.

Test Plan:
1. Reset low mid-FETCH with waitrequest = 1 → bus_read drops to 0 the same cycle; after release, state is IDLE and bus_error = 0.
2. Fetch-only at 0x0000_0006, waitrequest = 0, readdata 0x2402_0005 → bus_address 0x0000_0004; RESP in cycle 2 with instr_readdata 0x2402_0005, instr_valid = 1, cpu_stall = 0 only in that cycle.
3. Fetch plus store: data_address 0x100, byteenable 4'b0011, writedata 0xDEAD_BEEF, 2 wait cycles on the store → bus_write held 3 cycles with byteenable 0011; RESP at cycle 5.
4. DATA_FIRST = 1, fetch plus load → the bus_read for the data address precedes the fetch read; both valids are asserted in the same RESP cycle.
5. MAX_WAIT = 4, waitrequest stuck at 1 during FETCH → strobe drops after 4 cycles, bus_error = 1, instr_readdata = 0; the data phase proceeds and bus_error stays 1.
6. data_read and data_write both 1 → bus_write = 1 and bus_read = 0 in DATA.
